// File: rtl/move_input.sv
// move_input: synchronizes, debounces and edge-detects four push-buttons, then
// presents one encoded move at a time through a single-entry valid/ready register.
module move_input #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_ready,
  output logic [1:0] dir,
  output logic       move_valid,
  output logic [7:0] drop_count
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_next;
  logic [3:0]      raw, sync_a, sync_b, deb, press;
  logic [DB_W-1:0] cnt [4];
  logic            evt, load, hold_drop;
  logic [1:0]      code;
  logic [2:0]      n_press, pri_drops;
  logic [8:0]      drop_sum;
  logic [7:0]      drop_next;

  // Bit order doubles as priority: bit 0 (up) wins, bit 3 (right) loses.
  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle in which a debounced bit is about to rise.
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = (cnt[i] == CNT_LAST) && sync_b[i] && !deb[i];
  end

  always_comb begin
    code = 2'd0;
    if (press[0])      code = 2'd0;
    else if (press[1]) code = 2'd1;
    else if (press[2]) code = 2'd2;
    else if (press[3]) code = 2'd3;
    evt       = |press;
    n_press   = 3'(press[0]) + 3'(press[1]) + 3'(press[2]) + 3'(press[3]);
    pri_drops = evt ? (n_press - 3'd1) : 3'd0;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    hold_drop  = 1'b0;
    case (state)
      EMPTY: begin
        if (evt) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        if (move_ready) begin
          if (evt) load = 1'b1;
          else     state_next = EMPTY;
        end else if (evt) begin
          hold_drop = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Up to four discards can land in one cycle; clamp rather than wrap.
  always_comb begin
    drop_sum  = {1'b0, drop_count} + {6'd0, pri_drops} + {8'd0, hold_drop};
    drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      dir        <= 2'd0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_next;
      drop_count <= drop_next;
      if (load) dir <= code;
    end
  end

  assign move_valid = (state == FULL);

endmodule

// File: tb/tb_move_input.sv
// tb_move_input: table-driven directed vectors for move_input with a short
// debounce window, plus hand-written reset, saturation and mid-operation reset sequences.
module tb_move_input;

  localparam int DBC = 4;

  typedef struct {
    string      name;
    logic [3:0] btn;
    logic       ready;
    int         cycles;
    logic       exp_valid;
    logic [1:0] exp_dir;
    logic [7:0] exp_drop;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       move_ready = 1'b0;
  logic [1:0] dir;
  logic       move_valid;
  logic [7:0] drop_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  move_input #(.DB_CYCLES(DBC), .DB_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn[0]),
    .btn_down  (btn[1]),
    .btn_left  (btn[2]),
    .btn_right (btn[3]),
    .move_ready(move_ready),
    .dir       (dir),
    .move_valid(move_valid),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] b, input logic r,
                         input int c, input logic v, input logic [1:0] d,
                         input logic [7:0] dc);
    vec_t x;
    x.name = name; x.btn = b; x.ready = r; x.cycles = c;
    x.exp_valid = v; x.exp_dir = d; x.exp_drop = dc;
    vecs.push_back(x);
  endtask

  task automatic apply_stimulus(input logic [3:0] b, input logic r, input int c);
    btn        = b;
    move_ready = r;
    tick(c);
  endtask

  task automatic check_output(input string name, input logic v, input logic [1:0] d,
                              input logic [7:0] dc);
    n_checks++;
    if (move_valid !== v || dir !== d || drop_count !== dc) begin
      n_fail++;
      $display("[TB] FAIL %s: got valid=%b dir=%0d drop=%0d, required valid=%b dir=%0d drop=%0d",
               name, move_valid, dir, drop_count, v, d, dc);
    end
  endtask

  initial begin
    logic [7:0] exp_drop;
    logic       exp_full;

    // Clean press on left with the controller always ready
    add_vec("left_pre",     4'b0100, 1'b1, 5,  1'b0, 2'd0, 8'd0);
    add_vec("left_load",    4'b0100, 1'b1, 1,  1'b1, 2'd2, 8'd0);
    add_vec("left_xfer",    4'b0100, 1'b1, 1,  1'b0, 2'd2, 8'd0);
    add_vec("left_hold50",  4'b0100, 1'b1, 50, 1'b0, 2'd2, 8'd0);
    add_vec("left_release", 4'b0000, 1'b1, 10, 1'b0, 2'd2, 8'd0);
    // Bounce on up, two cycles per level
    for (int i = 0; i < 10; i++)
      add_vec("bounce", (i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 2, 1'b0, 2'd2, 8'd0);
    add_vec("bounce_quiet", 4'b0000, 1'b1, 10, 1'b0, 2'd2, 8'd0);
    // Backpressure: down loads, right arrives while full
    add_vec("bp_down",      4'b0010, 1'b0, 6,  1'b1, 2'd1, 8'd0);
    add_vec("bp_right_pre", 4'b1010, 1'b0, 5,  1'b1, 2'd1, 8'd0);
    add_vec("bp_right_drop",4'b1010, 1'b0, 1,  1'b1, 2'd1, 8'd1);
    add_vec("bp_xfer",      4'b1010, 1'b1, 1,  1'b0, 2'd1, 8'd1);
    add_vec("bp_idle",      4'b0000, 1'b0, 10, 1'b0, 2'd1, 8'd1);
    // Simultaneous up and right
    add_vec("sim_load",     4'b1001, 1'b0, 6,  1'b1, 2'd0, 8'd2);
    add_vec("sim_xfer",     4'b1001, 1'b1, 1,  1'b0, 2'd0, 8'd2);
    add_vec("sim_release",  4'b0000, 1'b1, 10, 1'b0, 2'd0, 8'd2);
    // Event lands on the same edge as a transfer
    add_vec("b2b_left",     4'b0100, 1'b0, 6,  1'b1, 2'd2, 8'd2);
    add_vec("b2b_down_pre", 4'b0110, 1'b0, 5,  1'b1, 2'd2, 8'd2);
    add_vec("b2b_reload",   4'b0110, 1'b1, 1,  1'b1, 2'd1, 8'd2);
    add_vec("b2b_drain",    4'b0110, 1'b1, 1,  1'b0, 2'd1, 8'd2);
    add_vec("b2b_release",  4'b0000, 1'b0, 10, 1'b0, 2'd1, 8'd2);

    // Reset held while buttons toggle
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn = 4'(i * 5 + 3);
      #3;
      check_output("reset_hold", 1'b0, 2'd0, 8'd0);
      tick(1);
    end
    btn = 4'd0;
    tick(2);
    rst = 1'b1;
    tick(3);
    check_output("after_release", 1'b0, 2'd0, 8'd0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].btn, vecs[i].ready, vecs[i].cycles);
      check_output(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_dir, vecs[i].exp_drop);
    end

    // Drive all four buttons repeatedly with no ready until drop_count clamps
    exp_drop = 8'd2;
    exp_full = 1'b0;
    for (int r = 0; r < 70; r++) begin
      apply_stimulus(4'b1111, 1'b0, DBC + 2);
      exp_drop = (int'(exp_drop) + (exp_full ? 4 : 3) > 255) ? 8'hFF
                 : exp_drop + (exp_full ? 8'd4 : 8'd3);
      exp_full = 1'b1;
      check_output("saturate", 1'b1, 2'd0, exp_drop);
      apply_stimulus(4'b0000, 1'b0, DBC + 4);
    end
    check_output("saturated_255", 1'b1, 2'd0, 8'hFF);

    // Reset while a move is pending, with down held across release
    btn = 4'b0010;
    tick(1);
    rst = 1'b0;
    #1;
    check_output("midreset_async", 1'b0, 2'd0, 8'd0);
    tick(3);
    rst = 1'b1;
    tick(DBC + 1);
    check_output("midreset_pre", 1'b0, 2'd0, 8'd0);
    tick(1);
    check_output("midreset_press", 1'b1, 2'd1, 8'd0);
    apply_stimulus(4'b0010, 1'b1, 1);
    check_output("midreset_xfer", 1'b0, 2'd1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_input.md
# move_input

Upstream input stage for `gameController`. It conditions four raw, asynchronous push-buttons into clean single-move requests. Each raw line is synchronized, debounced and rising-edge detected. The resulting press is encoded onto the 2-bit `dir` code and presented through a one-entry valid/ready holding register. A physical press therefore yields exactly one accepted move, and `dir` stays stable while the controller consumes it.

## Interface
- `DB_CYCLES`, default 500000: number of consecutive cycles a synchronized level must differ from the debounced state before the debounced state flips. Minimum 2.
- `DB_W`, default 20: debounce counter width. Must satisfy 2^DB_W > DB_CYCLES.
- `clk` in 1: single system clock. All state updates on posedge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw, asynchronous, active-high buttons.
- `move_ready` in 1: controller can accept a move this cycle.
- `dir` out 2: move code. 0 = up, 1 = down, 2 = left, 3 = right.
- `move_valid` out 1: a move is pending on `dir`.
- `drop_count` out 8: saturating count of presses discarded.

## Operation
- **Synchronizer:** two flops per button, reset to 0.
- **Debouncer:** one `DB_W` counter and one debounced bit per button. Each posedge:
  - sync == deb: cnt <= 0.
  - else if cnt == DB_CYCLES-1: deb <= sync, cnt <= 0.
  - else: cnt <= cnt+1.
- **Press event:** asserted in the cycle where deb is about to flip 0→1 (cnt == DB_CYCLES-1, sync = 1, deb = 0).
  - Release is debounced identically but produces no event.
  - A held button produces exactly one event.
- **Simultaneous events:** priority up > down > left > right. Lower-priority events in the same cycle are dropped, +1 each to `drop_count`.
- **Holding register:** states EMPTY (`move_valid` = 0) and FULL (`move_valid` = 1). Transfer occurs on a posedge with `move_valid` & `move_ready`.
  - EMPTY + event → FULL; `dir` <= encoded event.
  - FULL + transfer + no event → EMPTY.
  - FULL + transfer + event → stays FULL; `dir` <= new event. Back-to-back, no gap.
  - FULL + no transfer + event → event dropped, `drop_count`+1; `dir` unchanged.
- **`dir` hold:** `dir` keeps its last value after transfer and in EMPTY. It changes only when a new event is loaded.
- **`drop_count` saturation:** saturates at 255 and never wraps. It is cleared only by reset.
- **Reset:**
  - Asserting `rst` (0) immediately clears all state: sync flops, counters, deb bits, `dir` = 0, `move_valid` = 0, `drop_count` = 0. This applies mid-operation, including a pending move.
  - A button still held across reset release is treated as a new press.

## Timing
- Raw rising edge settled before posedge E1:
  - sync output is 1 after E2.
  - `move_valid` = 1 after posedge E(2+DB_CYCLES), with `dir` valid in the same cycle.
- Glitches or bounce shorter than DB_CYCLES cycles restart the counter and produce no event.
- Transfer completes in one cycle when `move_ready` is high. `move_valid` drops after that posedge unless it is reloaded.
- No combinational path from `move_ready` to `move_valid` or `dir`. All outputs are registered.
- Throughput: at most one move per cycle, bounded in practice by debounce.

## Test plan
- **Reset:** hold `rst` = 0 with all buttons toggling.
  - Required: `dir` = 0, `move_valid` = 0, `drop_count` = 0 throughout.
  - Required: no event before 2+DB_CYCLES posedges after release.
- **Clean press, DB_CYCLES = 4, `move_ready` = 1:** raise `btn_left` before E1.
  - Required: `move_valid` = 1 for exactly one cycle after E6, `dir` = 2.
  - Required: `dir` stays 2 afterwards; holding the button 50 cycles gives no second event.
- **Bounce:** toggle `btn_up` every 2 cycles for 20 cycles, then hold 0.
  - Required: `move_valid` never asserts; `drop_count` = 0.
- **Backpressure:** `move_ready` = 0; press down, then later right.
  - Required: `move_valid` = 1 with `dir` = 1 held, `drop_count` = 1.
  - Raise `move_ready` for 1 cycle. Required: one transfer, then `move_valid` = 0, `dir` = 1.
- **Simultaneous:** `btn_up` and `btn_right` rise in the same cycle.
  - Required: `dir` = 0, `drop_count` increments by 1.
  - Also: event arriving in the transfer cycle → `move_valid` stays 1 with the new `dir`.
- **Reset mid-operation:** pull `rst` low while FULL.
  - Required: `move_valid` = 0 and `drop_count` = 0 before the next posedge.
  - With `btn_down` held through release: `move_valid` = 1, `dir` = 1 after 2+DB_CYCLES posedges.
